// File: rtl/sad_accum_rtl_if.sv
// -----------------------------------------------------------------------------
// sad_accum_rtl_if
// Groups the streaming signals of the SAD accumulator into one bundle.
//   clear    : synchronous abort of the current block (driven by master)
//   in_val   : upstream diff valid                     (master -> slave)
//   in_rdy   : accumulator can accept a diff           (slave  -> master)
//   in_diff  : 4-bit unsigned absolute difference      (master -> slave)
//   out_val  : block sum valid                         (slave  -> master)
//   out_rdy  : downstream accepts the sum              (master -> slave)
//   out_sum  : accumulated (saturating) block sum      (slave  -> master)
//   count    : diffs accepted in the current block     (slave  -> master)
// The slave modport is the accumulator; the master modport is whatever
// drives it (upstream diff source plus downstream consumer).
// -----------------------------------------------------------------------------
interface sad_accum_rtl_if #(
  parameter int N         = 8,
  parameter int SUM_NBITS = 8
);
  logic                 clear;
  logic                 in_val;
  logic                 in_rdy;
  logic [3:0]           in_diff;
  logic                 out_val;
  logic                 out_rdy;
  logic [SUM_NBITS-1:0] out_sum;
  logic [$clog2(N):0]   count;

  modport master (
    output clear, in_val, in_diff, out_rdy,
    input  in_rdy, out_val, out_sum, count
  );

  modport slave (
    input  clear, in_val, in_diff, out_rdy,
    output in_rdy, out_val, out_sum, count
  );
endinterface

// File: rtl/sad_accum_rtl.sv
// -----------------------------------------------------------------------------
// sad_accum_rtl
// Sums blocks of N 4-bit absolute differences with saturation and hands each
// block sum downstream over a valid/ready handshake.
//   clk : clock, all state updates on the rising edge
//   rst : synchronous, active-high reset (highest priority)
//   bus : sad_accum_rtl_if.slave (clear, input and output handshakes, count)
// Every output is a pure function of registered state, so there is no
// combinational path from in_val/out_rdy to in_rdy/out_val.
// -----------------------------------------------------------------------------
module sad_accum_rtl #(
  parameter int N         = 8,
  parameter int SUM_NBITS = 8
) (
  input  logic              clk,
  input  logic              rst,
  sad_accum_rtl_if.slave    bus
);

  localparam int CNT_W = $clog2(N) + 1;

  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [SUM_NBITS-1:0] sum_q,   sum_d;
  logic [CNT_W-1:0]     cnt_q,   cnt_d;

  // One extra bit catches the carry out so overflow can clamp to all-ones.
  logic [SUM_NBITS:0]   sum_ext;
  logic [SUM_NBITS-1:0] sum_sat;

  assign sum_ext = {1'b0, sum_q} + (SUM_NBITS + 1)'(bus.in_diff);
  assign sum_sat = sum_ext[SUM_NBITS] ? '1 : sum_ext[SUM_NBITS-1:0];

  // NOTE: every signal assigned here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      ACCUM: begin
        // in_diff is only looked at on a transfer, so junk on an idle bus
        // never reaches the sum register.
        if (bus.in_val) begin
          sum_d = sum_sat;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(N - 1)) state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_rdy) begin
          state_d = ACCUM;
          sum_d   = '0;
          cnt_d   = '0;
        end
      end
      default: state_d = ACCUM;
    endcase

    // Abort overrides any transfer in flight, including a completed sum.
    if (bus.clear) begin
      state_d = ACCUM;
      sum_d   = '0;
      cnt_d   = '0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACCUM;
      sum_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.in_rdy  = (state_q == ACCUM);
  assign bus.out_val = (state_q == DONE);
  assign bus.out_sum = sum_q;
  assign bus.count   = cnt_q;

endmodule

// File: tb/tb_sad_accum_rtl.sv
// -----------------------------------------------------------------------------
// tb_sad_accum_rtl
// Drives two accumulators (SUM_NBITS=8 and SUM_NBITS=6, both N=8) with the
// same stimulus. A block-level model (running total, accepted count, done
// flag; saturation = min(total, max)) predicts every output each cycle, and
// directed sequences pin exact literal results.
// -----------------------------------------------------------------------------
module tb_sad_accum_rtl;

  localparam int N = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       clear;
  logic       in_val;
  logic [3:0] in_diff;
  logic       out_rdy;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // Block-level reference model.
  int m_total = 0;
  int m_cnt   = 0;
  bit m_done  = 1'b0;

  sad_accum_rtl_if #(.N(N), .SUM_NBITS(8)) if8 ();
  sad_accum_rtl_if #(.N(N), .SUM_NBITS(6)) if6 ();

  assign if8.clear   = clear;
  assign if8.in_val  = in_val;
  assign if8.in_diff = in_diff;
  assign if8.out_rdy = out_rdy;
  assign if6.clear   = clear;
  assign if6.in_val  = in_val;
  assign if6.in_diff = in_diff;
  assign if6.out_rdy = out_rdy;

  sad_accum_rtl #(.N(N), .SUM_NBITS(8)) dut8 (.clk(clk), .rst(rst), .bus(if8));
  sad_accum_rtl #(.N(N), .SUM_NBITS(6)) dut6 (.clk(clk), .rst(rst), .bus(if6));

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int total, input int nbits);
    int mx;
    mx = (1 << nbits) - 1;
    return (total > mx) ? mx : total;
  endfunction

  // Model update at the same edge the DUTs see.
  always @(posedge clk) begin
    if (rst || clear) begin
      m_total = 0;
      m_cnt   = 0;
      m_done  = 1'b0;
    end else if (!m_done) begin
      if (in_val) begin
        m_total = m_total + int'(in_diff);
        m_cnt   = m_cnt + 1;
        if (m_cnt == N) m_done = 1'b1;
      end
    end else if (out_rdy) begin
      m_total = 0;
      m_cnt   = 0;
      m_done  = 1'b0;
    end
  end

  // Every-cycle compare, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("m8 in_rdy",  int'(if8.in_rdy),  int'(!m_done));
      check("m8 out_val", int'(if8.out_val), int'(m_done));
      check("m8 count",   int'(if8.count),   m_cnt);
      check("m8 out_sum", int'(if8.out_sum), sat(m_total, 8));
      check("m6 in_rdy",  int'(if6.in_rdy),  int'(!m_done));
      check("m6 out_val", int'(if6.out_val), int'(m_done));
      check("m6 count",   int'(if6.count),   m_cnt);
      check("m6 out_sum", int'(if6.out_sum), sat(m_total, 6));
    end
  end

  task automatic step(input bit v, input logic [3:0] d);
    in_val  = v;
    in_diff = d;
    @(negedge clk);
  endtask

  task automatic check_idle(input string tag);
    check({tag, " in_rdy"},  int'(if8.in_rdy),  1);
    check({tag, " out_val"}, int'(if8.out_val), 0);
    check({tag, " out_sum"}, int'(if8.out_sum), 0);
    check({tag, " count"},   int'(if8.count),   0);
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; in_val = 1'b0; in_diff = 4'd0; out_rdy = 1'b1;
    repeat (2) @(negedge clk);
    rst    = 1'b0;
    chk_en = 1'b1;
    check_idle("reset");

    // Block 1..8, downstream always ready.
    for (int i = 1; i <= 8; i++) begin
      check("seq in_rdy", int'(if8.in_rdy), 1);
      step(1'b1, 4'(i));
    end
    check("seq out_val", int'(if8.out_val), 1);
    check("seq out_sum", int'(if8.out_sum), 36);
    check("seq count",   int'(if8.count),   8);
    check("seq in_rdy0", int'(if8.in_rdy),  0);
    step(1'b0, 4'd0);
    check_idle("seq after");

    // Downstream stalls for 5 cycles; input during DONE is ignored.
    for (int i = 1; i <= 8; i++) step(1'b1, 4'(i));
    out_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("stall out_val", int'(if8.out_val), 1);
      check("stall out_sum", int'(if8.out_sum), 36);
      step(1'b1, 4'd9);
    end
    out_rdy = 1'b1;
    step(1'b0, 4'd0);
    check_idle("stall after");

    // Saturation: 8 x 15 = 120 fits in 8 bits, clamps to 63 in 6 bits.
    for (int i = 0; i < 8; i++) step(1'b1, 4'd15);
    check("sat8 out_sum", int'(if8.out_sum), 120);
    check("sat6 out_sum", int'(if6.out_sum), 63);
    step(1'b0, 4'd0);

    // Alternating valid; idle cycles carry X on in_diff.
    out_rdy = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 4'd4);
      if (i < 7) step(1'b0, 4'bxxxx);
    end
    check("toggle out_val", int'(if8.out_val), 1);
    check("toggle out_sum", int'(if8.out_sum), 32);
    out_rdy = 1'b1;
    step(1'b0, 4'd0);

    // Clear mid-block drops the concurrent diff.
    for (int i = 0; i < 3; i++) step(1'b1, 4'd5);
    check("pre-clear count", int'(if8.count),   3);
    check("pre-clear sum",   int'(if8.out_sum), 15);
    clear = 1'b1;
    step(1'b1, 4'd7);
    clear = 1'b0;
    check_idle("clear");
    for (int i = 0; i < 8; i++) step(1'b1, 4'd2);
    check("post-clear out_sum", int'(if8.out_sum), 16);
    step(1'b0, 4'd0);

    // Reset mid-block, then reset while holding a finished sum.
    for (int i = 0; i < 5; i++) step(1'b1, 4'd3);
    check("pre-rst count", int'(if8.count), 5);
    rst = 1'b1;
    step(1'b1, 4'd3);
    rst = 1'b0;
    check_idle("rst mid");
    out_rdy = 1'b0;
    for (int i = 0; i < 8; i++) step(1'b1, 4'd1);
    check("pre-rst done", int'(if8.out_val), 1);
    rst = 1'b1;
    step(1'b0, 4'd0);
    rst = 1'b0;
    check_idle("rst done");

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      rst     = ($urandom_range(0, 199) == 0);
      clear   = ($urandom_range(0, 49) == 0);
      out_rdy = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 1) == 1) step($urandom_range(0, 3) != 0, 4'($urandom_range(12, 15)));
      else                            step($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)));
    end
    rst = 1'b0; clear = 1'b0; in_val = 1'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sad_accum_rtl.md
Name: sad_accum_rtl

Overview:
- Sequential sum-of-absolute-differences accumulator that sits directly downstream of the 4-bit absolute-difference unit.
- Consumes a stream of 4-bit diff values over a valid/ready handshake and sums each block of N values.
- Presents the block sum on a second valid/ready handshake to the next stage, e.g. a motion-estimation compare/min stage.

Parameters:
- N, 8, number of diffs per block (N >= 2).
- SUM_NBITS, 8, width of the accumulated sum. The sum saturates if SUM_NBITS is too narrow for 15*N.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- clear  input  1  synchronous abort of the current block
- in_val  input  1  upstream diff is valid
- in_rdy  output  1  accumulator can accept a diff
- in_diff  input  4  absolute difference from the upstream stage
- out_val  output  1  block sum is valid
- out_rdy  input  1  downstream accepts the sum
- out_sum  output  SUM_NBITS  accumulated block sum
- count  output  $clog2(N)+1  number of diffs accepted in the current block

Behaviour:
- State machine has two states, ACCUM and DONE. Registers are state, sum (SUM_NBITS) and cnt.
- Reset (rst=1 at a rising edge) forces state=ACCUM, sum=0 and cnt=0.
  - Outputs after reset: in_rdy=1, out_val=0, out_sum=0, count=0.
  - rst has priority over clear and all handshakes, including mid-block and during DONE; a pending sum is discarded.
- in_rdy = (state==ACCUM). out_val = (state==DONE). All outputs are driven directly from registers or state; no combinational path exists from in_val or out_rdy to in_rdy or out_val.
- Input transfer occurs when in_val && in_rdy.
- In ACCUM, on a transfer:
  - sum <= sat(sum + in_diff) and cnt <= cnt+1.
  - If the pre-increment cnt == N-1, the next state is DONE. The final sum includes this last diff.
- In ACCUM with no transfer, all state holds.
- Latency: the sum is visible on out_sum with out_val=1 in the cycle after the Nth transfer. Back-to-back input transfers are accepted every cycle.
- out_sum always equals the sum register. Intermediate partial sums are visible but only qualified by out_val.
- In DONE:
  - sum and cnt hold (cnt==N) and in_val is ignored.
  - When out_rdy=1: next state ACCUM, sum <= 0, cnt <= 0. in_rdy rises the cycle after the output transfer (one bubble per block).
  - When out_rdy=0: out_val and out_sum remain stable indefinitely.
- clear (when rst=0) forces state=ACCUM, sum=0 and cnt=0 next cycle, in any state. An input transfer in the same cycle is discarded, and a DONE sum is dropped even if out_rdy=1.
- Saturation: if sum + in_diff > 2^SUM_NBITS-1, sum <= 2^SUM_NBITS-1. Once saturated, sum stays at the maximum until the block ends. The addition is computed at SUM_NBITS+1 bits.
- in_diff is zero-extended and treated as unsigned 0..15.
- Values on in_diff when in_val=0 must not affect state. X on in_diff without in_val must not propagate into sum.

Test Plan:
- Reset, then 8 transfers of diffs 1,2,3,4,5,6,7,8 with in_val held high and out_rdy=1 → in_rdy=1 throughout; the cycle after the 8th transfer shows out_val=1, out_sum=36, count=8, in_rdy=0; the next cycle shows out_val=0, out_sum=0, count=0, in_rdy=1.
- Same stream of 8 diffs but out_rdy=0 for 5 cycles after completion → out_val=1 and out_sum=36 stable for all 5 cycles; in_val=1 with in_diff=9 during DONE is ignored; after out_rdy=1 the next block starts from 0.
- Eight diffs of 15 with SUM_NBITS=6 (max 63) → out_sum=63 (saturated, not 120 mod 64=56); with default SUM_NBITS=8 → out_sum=120.
- in_val toggling 1,0,1,0 with diffs 4,X,4,X... for 8 valid diffs of 4 → out_sum=32; the diffs presented while in_val=0 do not affect sum or count.
- After 3 diffs of 5 (count=3, out_sum=15), assert clear with in_val=1 and in_diff=7 → next cycle sum=0, count=0, state ACCUM (the diff of 7 is dropped); a subsequent 8 diffs of 2 gives out_sum=16.
- rst asserted mid-block (count=5) and separately during DONE with out_val=1 → next cycle out_val=0, out_sum=0, count=0, in_rdy=1.
